// File: rtl/col_tag_gen_if.sv
// Beat handshake and tag bus between the column tag generator,
// its upstream beat source (in_valid/in_ready) and the tag buffer (flush_tag/tag_out).
interface col_tag_gen_if #(
   parameter int TW = 3
);
   logic          in_valid;
   logic          in_ready;
   logic          flush_tag;
   logic [TW-1:0] tag_out;

   modport master (
      output in_valid,
      input  in_ready,
      input  flush_tag,
      input  tag_out
   );

   modport slave (
      input  in_valid,
      output in_ready,
      output flush_tag,
      output tag_out
   );
endinterface

// File: rtl/col_tag_gen.sv
// Column tag generator: counts accepted beats per column and pulses
// flush_tag with the 1-based completed-column count; done after the last column.
// Ports: clk, rstn (async low), start, abort, busy, done; bus.slave carries
// in_valid/in_ready and flush_tag/tag_out.
module col_tag_gen #(
   parameter int NUM_COL       = 4,
   parameter int BEATS_PER_COL = 9,
   parameter int TW            = $clog2(NUM_COL) + 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   col_tag_gen_if.slave bus
);

   localparam int BW =
      (BEATS_PER_COL > 1) ? $clog2(BEATS_PER_COL) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_COL - 1);
   localparam logic [TW-1:0] COL_LAST  = TW'(NUM_COL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [BW-1:0] beat_cnt;
   logic [TW-1:0] col_cnt;
   logic [TW-1:0] tag_q;
   logic          acc;
   logic          col_end;

   assign acc     = bus.in_valid & (state_q == RUN);
   assign col_end = acc & (beat_cnt == BEAT_LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (col_end) state_d = FLUSH;
         FLUSH:   state_d = (col_cnt == COL_LAST) ? DONE : RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort beats start, so start+abort in IDLE stays put
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         beat_cnt <= '0;
         col_cnt  <= '0;
         tag_q    <= '0;
      end else begin
         state_q <= state_d;
         if (abort) begin
            beat_cnt <= '0;
            col_cnt  <= '0;
            tag_q    <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     beat_cnt <= '0;
                     col_cnt  <= '0;
                     tag_q    <= '0;
                  end
               end
               RUN: begin
                  if (col_end) begin
                     beat_cnt <= '0;
                     col_cnt  <= col_cnt + 1'b1;
                     // tag lands together with entry to FLUSH
                     tag_q    <= col_cnt + 1'b1;
                  end else if (acc) begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready  = (state_q == RUN);
   assign bus.flush_tag = (state_q == FLUSH);
   assign bus.tag_out   = tag_q;
   assign busy          = (state_q == RUN) | (state_q == FLUSH);
   assign done          = (state_q == DONE);

endmodule
